// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM between the VGA scanout path and a
// CPU-side requester. Display pixels (RGB332) are prefetched into a small
// show-ahead FIFO so the pixel-timing logic always has the next pixel at the
// head. CPU reads and writes use a req/ack handshake and are slotted into
// memory cycles the display does not urgently need.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   frame_start        pulse: restart scanout at address 0, flush FIFO
//   pix_rd             display pops the FIFO head this cycle
//   pix_data/pix_valid FIFO head and non-empty flag
//   underrun           sticky flag: pix_rd seen while the FIFO was empty
//   underrun_cnt       saturating underrun event count (optional)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata  one-cycle completion pulse and read data
//   mem_en/mem_we/mem_addr/mem_wdata    RAM command (registered)
//   mem_rdata          RAM read data, valid the cycle after a read issue
//
// Optional build macro: VGA_FB_UNDERRUN_CNT_EN adds the underrun_cnt output.
//
// Memory access pipeline: an access decided at a clock edge is on the RAM
// port during cycle N, its data returns in N+1 and a display pixel is written
// into the FIFO at the end of N+1 (visible in N+2).
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int FB_PIXELS  = 76800,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic              underrun,
`ifdef VGA_FB_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Occupancy can briefly count FIFO entries plus two reads in flight.
    localparam int OCC_W = PTR_W + 2;

    localparam logic [OCC_W-1:0]  LOW_WM_OCC = OCC_W'(LOW_WM);
    localparam logic [OCC_W-1:0]  DEPTH_OCC  = OCC_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_PIXELS - 1);

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_ISSUE,
        CPU_WAIT,
        CPU_ACK
    } cpu_state_t;

    cpu_state_t cpu_state_reg;
    logic       cpu_we_reg;

    // Display fetch pipeline: iss = display read on the RAM port this cycle,
    // ret = display read whose data is on mem_rdata this cycle. Clearing
    // these on frame_start is what marks in-flight reads as stale.
    logic              iss_disp_reg;
    logic              ret_disp_reg;
    logic [ADDR_W-1:0] fetch_addr_reg;

    // Pixel FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // ---------------------------------------------------------------------
    // Arbitration. frame_start acts in the same cycle, so the decision is
    // made against the post-flush view: empty FIFO, nothing in flight and
    // fetch address 0.
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0]  eff_count;
    logic              eff_iss;
    logic              eff_ret;
    logic [ADDR_W-1:0] eff_addr;
    logic [OCC_W-1:0]  occ;
    logic              below_low;
    logic              has_room;
    logic              cpu_avail;
    logic              disp_grant;
    logic              cpu_grant;
    logic [ADDR_W-1:0] addr_next;

    assign eff_count = frame_start ? '0 : count_reg;
    assign eff_iss   = iss_disp_reg & ~frame_start;
    assign eff_ret   = ret_disp_reg & ~frame_start;
    assign eff_addr  = frame_start ? '0 : fetch_addr_reg;

    assign occ = OCC_W'(eff_count) + OCC_W'(eff_iss) + OCC_W'(eff_ret);

    assign below_low  = (occ < LOW_WM_OCC);
    assign has_room   = (occ < DEPTH_OCC);
    assign cpu_avail  = cpu_req && (cpu_state_reg == CPU_IDLE);
    assign disp_grant = below_low | (has_room & ~cpu_avail);
    assign cpu_grant  = cpu_avail & ~below_low;

    assign addr_next = (eff_addr == LAST_ADDR) ? '0 : eff_addr + ADDR_W'(1);

    // ---------------------------------------------------------------------
    // RAM command registers and display fetch pipeline
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            fetch_addr_reg <= '0;
            iss_disp_reg   <= 1'b0;
            ret_disp_reg   <= 1'b0;
        end else begin
            mem_en <= disp_grant | cpu_grant;
            mem_we <= cpu_grant & cpu_we;
            if (cpu_grant) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (disp_grant) begin
                mem_addr <= eff_addr;
            end
            fetch_addr_reg <= disp_grant ? addr_next : eff_addr;
            iss_disp_reg   <= disp_grant;
            ret_disp_reg   <= eff_iss;
        end
    end

    // ---------------------------------------------------------------------
    // CPU sequencer: ISSUE is the RAM cycle, WAIT carries the returning
    // data, ACK presents the registered result. Requests are only looked at
    // in IDLE, so a request still high during ACK is picked up one cycle
    // later as a fresh transaction.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_state_reg <= CPU_IDLE;
            cpu_we_reg    <= 1'b0;
            cpu_ack       <= 1'b0;
            cpu_rdata     <= '0;
        end else begin
            cpu_ack <= 1'b0;
            unique case (cpu_state_reg)
                CPU_IDLE: begin
                    if (cpu_grant) begin
                        cpu_state_reg <= CPU_ISSUE;
                        cpu_we_reg    <= cpu_we;
                    end
                end
                CPU_ISSUE: cpu_state_reg <= CPU_WAIT;
                CPU_WAIT: begin
                    cpu_state_reg <= CPU_ACK;
                    cpu_ack       <= 1'b1;
                    // Write acks leave the last read value untouched.
                    if (!cpu_we_reg) begin
                        cpu_rdata <= mem_rdata;
                    end
                end
                CPU_ACK:  cpu_state_reg <= CPU_IDLE;
                default:  cpu_state_reg <= CPU_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Pixel FIFO. The head is kept in a register (pix_data) so the display
    // sees a registered output; it is reloaded from the next stored entry
    // on a pop, or directly from mem_rdata when the incoming pixel becomes
    // the new head.
    // ---------------------------------------------------------------------
    logic             push;
    logic             pop;
    logic             empty_rd;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] rd_ptr_inc;

    assign push       = eff_ret;
    assign pop        = pix_rd & ~frame_start & (count_reg != '0);
    assign empty_rd   = pix_rd & ~frame_start & (count_reg == '0);
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            pix_valid <= (count_next != '0);
            if (empty_rd) begin
                underrun <= 1'b1;
            end
            if (pop) begin
                if (count_reg > CNT_W'(1)) begin
                    pix_data <= fifo_mem[rd_ptr_inc];
                end else if (push) begin
                    pix_data <= mem_rdata;
                end
            end else if (push && (count_reg == '0)) begin
                pix_data <= mem_rdata;
            end
        end
    end

`ifdef VGA_FB_UNDERRUN_CNT_EN
    // Event counter survives frame_start; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (empty_rd && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Randomized bench for vga_fb_arbiter with a transaction-level reference
// model: expected pixels are queued with the cycle they become visible,
// CPU transactions are tracked by grant/ack timestamps, and the priority
// rules are evaluated from modelled occupancy. FB_PIXELS is overridden to 16
// so the fetch address wraps often. CPU traffic stays at addresses >= 16 so
// display pixels always equal the initial RAM pattern.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    localparam int ADDR_W   = 17;
    localparam int FB_PIX   = 16;
    localparam int DEPTH    = 8;
    localparam int LOW_WM   = 2;
    localparam int N_CYCLES = 3000;
    localparam int RAM_SIZE = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              pix_rd;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              underrun;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
`ifdef VGA_FB_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .FB_PIXELS  (FB_PIX),
        .FIFO_DEPTH (DEPTH),
        .LOW_WM     (LOW_WM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pix_rd       (pix_rd),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .underrun     (underrun),
`ifdef VGA_FB_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Framebuffer RAM: registered read, data valid the cycle after issue.
    logic [7:0] ram [0:RAM_SIZE-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        int addr;
        int cyc;
    } infl_t;

    logic [7:0] fifo_q [$];
    infl_t      infl_q [$];
    logic [7:0] shadow [0:RAM_SIZE-1];
    int         fetch_ptr;
    bit         m_underrun;
    int         m_cnt;
    int         cpu_free;
    int         ack_cyc;
    bit         ack_rd;
    logic [7:0] ack_data;
    logic [7:0] m_rdata;
    bit         exp_en;
    bit         exp_we;
    int         exp_addr;
    logic [7:0] exp_wdata;
    bit         prev_reset;

    // ---------------- CPU driver state ----------------
    bit                drv_active;
    int                dir_idx;
    int                rst_left;

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) begin
            ram[i]    = pat(i);
            shadow[i] = pat(i);
        end
        reset       = 1'b1;
        frame_start = 1'b0;
        pix_rd      = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        drv_active  = 0;
        dir_idx     = 0;
        rst_left    = 0;
        fetch_ptr   = 0;
        m_underrun  = 0;
        m_cnt       = 0;
        cpu_free    = 0;
        ack_cyc     = -1;
        ack_rd      = 0;
        ack_data    = '0;
        m_rdata     = '0;
        exp_en      = 0;
        exp_we      = 0;
        exp_addr    = 0;
        exp_wdata   = '0;
        prev_reset  = 1;

        for (int c = 0; c < N_CYCLES; c++) begin
            int occ;
            int fa;
            bit cpu_can;

            @(negedge clk);
            cyc = c;

            // ---------- observe cycle c ----------
            check("mem_en", mem_en, exp_en);
            check("mem_we", mem_we, exp_we);
            if (exp_en) begin
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (prev_reset) begin
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_wdata", mem_wdata, 0);
                check("rst_pix_data", pix_data, 0);
            end
            check("pix_valid", pix_valid, fifo_q.size() != 0);
            if (fifo_q.size() != 0) check("pix_data", pix_data, fifo_q[0]);
            check("underrun", underrun, m_underrun);
`ifdef VGA_FB_UNDERRUN_CNT_EN
            check("underrun_cnt", underrun_cnt, m_cnt);
`endif
            check("cpu_ack", cpu_ack, c == ack_cyc);
            if (c == ack_cyc && ack_rd) m_rdata = ack_data;
            check("cpu_rdata", cpu_rdata, m_rdata);
            if (cpu_ack && drv_active)
                $display("cpu txn cycle %0d: we=%0d addr=%05h data=%02h", c, cpu_we, cpu_addr,
                         cpu_we ? cpu_wdata : cpu_rdata);

            // ---------- drive inputs for cycle c ----------
            if (c < 3) begin
                reset = 1'b1;
            end else if (c >= 200 && rst_left == 0 && $urandom_range(0, 499) == 0) begin
                rst_left = 2;
            end
            if (c >= 3) begin
                reset = (rst_left > 0);
                if (rst_left > 0) rst_left--;
            end

            if (c < 40)        pix_rd = 1'b1;
            else if (c < 110)  pix_rd = 1'b0;
            else               pix_rd = ($urandom_range(0, 99) < 55);

            if (c == 40)       frame_start = 1'b1;
            else if (c >= 110) frame_start = ($urandom_range(0, 79) == 0);
            else               frame_start = 1'b0;

            if (drv_active && cpu_ack) drv_active = 0;
            if (reset) begin
                drv_active = 0;
            end else if (!drv_active && c >= 90) begin
                if (dir_idx == 0) begin
                    drv_active = 1; cpu_we = 1'b1; cpu_addr = ADDR_W'(17'h00100); cpu_wdata = 8'hE3;
                    dir_idx++;
                end else if (dir_idx == 1) begin
                    drv_active = 1; cpu_we = 1'b0; cpu_addr = ADDR_W'(17'h00100); cpu_wdata = 8'h00;
                    dir_idx++;
                end else if ($urandom_range(0, 9) < 3) begin
                    drv_active = 1;
                    cpu_we     = $urandom_range(0, 1) == 1;
                    cpu_addr   = ADDR_W'(16 + $urandom_range(0, 63));
                    cpu_wdata  = 8'($urandom_range(0, 255));
                end
            end
            cpu_req = drv_active;

            // ---------- model the edge ending cycle c ----------
            if (reset) begin
                fifo_q.delete();
                infl_q.delete();
                fetch_ptr  = 0;
                m_underrun = 0;
                m_cnt      = 0;
                cpu_free   = c + 1;
                ack_cyc    = -1;
                m_rdata    = '0;
                exp_en     = 0;
                exp_we     = 0;
                prev_reset = 1;
            end else begin
                prev_reset = 0;
                if (frame_start) begin
                    occ = 0;
                    fa  = 0;
                end else begin
                    occ = fifo_q.size() + infl_q.size();
                    fa  = fetch_ptr;
                end
                cpu_can = cpu_req && (c >= cpu_free);

                if (frame_start) begin
                    fifo_q.delete();
                    infl_q.delete();
                    m_underrun = 0;
                end else begin
                    if (pix_rd) begin
                        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                        else begin
                            m_underrun = 1;
                            if (m_cnt < 65535) m_cnt++;
                        end
                    end
                    while (infl_q.size() > 0 && infl_q[0].cyc == c - 1) begin
                        fifo_q.push_back(pat(infl_q[0].addr));
                        void'(infl_q.pop_front());
                    end
                end

                fetch_ptr = fa;
                exp_en    = 0;
                exp_we    = 0;
                if (occ < LOW_WM || (!cpu_can && occ < DEPTH)) begin
                    exp_en    = 1;
                    exp_addr  = fa;
                    infl_q.push_back('{fa, c + 1});
                    fetch_ptr = (fa + 1) % FB_PIX;
                end else if (cpu_can) begin
                    exp_en    = 1;
                    exp_we    = cpu_we;
                    exp_addr  = int'(cpu_addr);
                    exp_wdata = cpu_wdata;
                    cpu_free  = c + 4;
                    ack_cyc   = c + 3;
                    ack_rd    = !cpu_we;
                    if (cpu_we) shadow[cpu_addr] = cpu_wdata;
                    else        ack_data = shadow[cpu_addr];
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
